calc_entry_ctrl: RTL
====================

Name: calc_entry_ctrl

Overview:
- Front-end sequencer for the 4-bit add/sub calculator datapath.
- Synchronises and debounces the raw push-buttons (x1, x0, add, sub, result).
- Assembles operands A then B serially, MSB first, and latches the selected operation.
- Issues a one-cycle start pulse to the ALU, waits for its done, then holds the block in result-display mode until new entry begins.

Parameters:
- WIDTH, 4, operand width in bits.
- DB_CYCLES, 8388608, consecutive stable cycles required to accept a press or a release.
- DB_W, 24, width of each debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- x1  in  1  raw button, enter bit 1
- x0  in  1  raw button, enter bit 0
- add  in  1  raw button, select addition
- sub  in  1  raw button, select subtraction
- result  in  1  raw button, request execution
- alu_done  in  1  one-cycle pulse from ALU, result valid
- alu_error  in  1  ALU overflow flag, sampled with alu_done
- a  out  WIDTH  operand A
- b  out  WIDTH  operand B
- bit_idx  out  $clog2(WIDTH)  next bit position to be written
- sel_b  out  1  1 while operand B is being entered
- op_valid  out  1  an operation has been selected
- op_sub  out  1  1 = subtract, 0 = add (meaningful only when op_valid=1)
- start  out  1  one-cycle execute pulse to the ALU
- busy  out  1  high while waiting for alu_done
- show_result  out  1  display should show the ALU result
- err  out  1  latched alu_error of the last execution

Behaviour:
- Reset (clr_n=0, asynchronous), all registers and outputs cleared:
  - state=ENTER_A, a=0, b=0, bit_idx=WIDTH-1.
  - sel_b, op_valid, op_sub, start, busy, show_result, err all 0.
  - Synchronisers and debounce counters cleared.
  - Reset applies immediately, in any state, including EXEC.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce FSM: IDLE -> PRESSED after DB_CYCLES consecutive synced-high cycles; emits exactly one press pulse on that transition.
  - PRESSED -> IDLE after DB_CYCLES consecutive synced-low cycles.
  - A glitch resets the counter.
  - Holding a button produces one pulse only.
- Pulse arbitration within one cycle:
  - x1 beats x0.
  - add and sub pulsing together: both ignored, op unchanged.
  - A bit pulse and an op pulse in the same cycle are both honoured.
  - result is handled independently, per state.
- State machine. Every update is visible on the cycle after the press pulse.
  - ENTER_A (sel_b=0):
    - Bit pulse writes a[bit_idx].
    - If bit_idx==0: bit_idx<=WIDTH-1, go to ENTER_B.
    - Otherwise bit_idx decrements.
    - result pulse is ignored.
  - ENTER_B (sel_b=1):
    - Bit pulse writes b[bit_idx].
    - If bit_idx==0: bit_idx<=WIDTH-1, go to READY.
    - Otherwise bit_idx decrements.
    - result pulse is ignored.
  - READY:
    - result pulse with op_valid=1: go to EXEC, start=1 for exactly one cycle, busy=1.
    - result pulse with op_valid=0: ignored.
    - Bit pulses are ignored.
  - EXEC:
    - Waits indefinitely for alu_done.
    - On alu_done: err<=alu_error, busy<=0, show_result<=1, go to SHOW.
    - Bit, op and result pulses are ignored.
  - SHOW:
    - result pulse: re-execute with the same operands (EXEC, start pulse, show_result<=0).
    - add/sub pulse updates op_sub; show_result stays 1.
    - Bit pulse starts a new entry: show_result=0, err=0, op_valid=0, a<=pressed bit in MSB with the other bits 0, b=0, bit_idx=WIDTH-2, go to ENTER_A.
- Operation select (add/sub pulse) in ENTER_A, ENTER_B, READY and SHOW: op_valid<=1, op_sub<=(sub).
- alu_done outside EXEC is ignored. start never asserts outside the READY/SHOW -> EXEC transition.
- Outputs are registered; no combinational path from any input to any output.

Test Plan (DB_CYCLES=4, DB_W=3):
- Reset, then hold x1 for 20 cycles -> exactly one accepted press; a=4'b1000, bit_idx=2; no second write.
- Key sequence 1,0,1,1,0,0,1,0 then sub, then result -> a=4'b1011, b=4'b0010, op_sub=1, start high exactly 1 cycle, busy=1. alu_done with alu_error=0 -> show_result=1, busy=0, err=0.
- result pressed before B is complete, or with op_valid=0 in READY -> no start, state unchanged.
- x1 and x0 raised together; then add and sub raised together -> bit written as 1; op_valid stays 0.
- In SHOW, press x0 -> show_result=0, a=4'b0000, b=0, bit_idx=2, op_valid=0. In SHOW, press result instead -> a new start pulse with unchanged a and b.
- Drop clr_n in EXEC with busy=1 -> all outputs cleared within the same cycle; a later alu_done is ignored.
- Bounce on x1 (high 2, low 1, high 2 cycles) -> no accepted press.

Source files
------------

// File: rtl/calc_entry_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : calc_entry_ctrl
// Brief   : Button conditioning and operand/operation entry sequencer for the
//           add/sub calculator ALU.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module calc_entry_ctrl #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 8388608,
    parameter int DB_W      = 24
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     x1,
    input  logic                     x0,
    input  logic                     add,
    input  logic                     sub,
    input  logic                     result,
    input  logic                     alu_done,
    input  logic                     alu_error,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     sel_b,
    output logic                     op_valid,
    output logic                     op_sub,
    output logic                     start,
    output logic                     busy,
    output logic                     show_result,
    output logic                     err
);

    localparam int NBTN  = 5;
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [DB_W-1:0]  c_db_last  = DB_W'(DB_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_idx_msb  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] c_idx_next = IDX_W'(WIDTH - 2);

    typedef enum logic {
        DB_IDLE    = 1'b0,
        DB_PRESSED = 1'b1
    } db_state_t;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_READY   = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SHOW    = 3'd4
    } state_t;

    // Button order: {result, sub, add, x0, x1}
    logic [NBTN-1:0] w_raw;
    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [NBTN-1:0] w_press;

    assign w_raw = {result, sub, add, x0, x1};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        db_state_t       r_db;
        db_state_t       w_db_nxt;
        logic [DB_W-1:0] r_cnt;
        logic [DB_W-1:0] w_cnt_nxt;
        logic            r_pulse;
        logic            w_pulse_nxt;

        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                r_db    <= DB_IDLE;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_db    <= w_db_nxt;
                r_cnt   <= w_cnt_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        // Counter only advances on consecutive cycles at the opposite level.
        always_comb begin
            w_db_nxt    = r_db;
            w_cnt_nxt   = '0;
            w_pulse_nxt = 1'b0;
            case (r_db)
                DB_IDLE: begin
                    if (r_sync2[g]) begin
                        if (r_cnt == c_db_last) begin
                            w_db_nxt    = DB_PRESSED;
                            w_pulse_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                DB_PRESSED: begin
                    if (!r_sync2[g]) begin
                        if (r_cnt == c_db_last) begin
                            w_db_nxt = DB_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: w_db_nxt = DB_IDLE;
            endcase
        end

        assign w_press[g] = r_pulse;
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_op_valid_nxt;
    logic               w_op_sub_nxt;
    logic               w_start_nxt;
    logic               w_busy_nxt;
    logic               w_show_nxt;
    logic               w_err_nxt;
    logic               w_bit_pulse;
    logic               w_bit_val;
    logic               w_op_pulse;
    logic               w_res_pulse;

    assign w_bit_pulse = w_press[0] | w_press[1];
    assign w_bit_val   = w_press[0];
    assign w_op_pulse  = w_press[2] ^ w_press[3];
    assign w_res_pulse = w_press[4];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= ST_ENTER_A;
            a           <= '0;
            b           <= '0;
            bit_idx     <= c_idx_msb;
            sel_b       <= 1'b0;
            op_valid    <= 1'b0;
            op_sub      <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            show_result <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            a           <= w_a_nxt;
            b           <= w_b_nxt;
            bit_idx     <= w_idx_nxt;
            sel_b       <= (w_state_nxt == ST_ENTER_B);
            op_valid    <= w_op_valid_nxt;
            op_sub      <= w_op_sub_nxt;
            start       <= w_start_nxt;
            busy        <= w_busy_nxt;
            show_result <= w_show_nxt;
            err         <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = a;
        w_b_nxt        = b;
        w_idx_nxt      = bit_idx;
        w_op_valid_nxt = op_valid;
        w_op_sub_nxt   = op_sub;
        w_start_nxt    = 1'b0;
        w_busy_nxt     = busy;
        w_show_nxt     = show_result;
        w_err_nxt      = err;
        case (r_state)
            ST_ENTER_A, ST_ENTER_B: begin
                if (w_bit_pulse) begin
                    if (r_state == ST_ENTER_A) begin
                        w_a_nxt[bit_idx] = w_bit_val;
                    end else begin
                        w_b_nxt[bit_idx] = w_bit_val;
                    end
                    if (bit_idx == '0) begin
                        w_idx_nxt   = c_idx_msb;
                        w_state_nxt = (r_state == ST_ENTER_A) ? ST_ENTER_B : ST_READY;
                    end else begin
                        w_idx_nxt = bit_idx - 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (w_res_pulse && op_valid) begin
                    w_state_nxt = ST_EXEC;
                    w_start_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_EXEC: begin
                if (alu_done) begin
                    w_state_nxt = ST_SHOW;
                    w_err_nxt   = alu_error;
                    w_busy_nxt  = 1'b0;
                    w_show_nxt  = 1'b1;
                end
            end
            ST_SHOW: begin
                if (w_res_pulse) begin
                    w_state_nxt = ST_EXEC;
                    w_start_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_show_nxt  = 1'b0;
                end else if (w_bit_pulse) begin
                    // The pressed key is the first bit of a fresh operand A.
                    w_state_nxt           = ST_ENTER_A;
                    w_a_nxt               = '0;
                    w_a_nxt[WIDTH-1]      = w_bit_val;
                    w_b_nxt               = '0;
                    w_idx_nxt             = c_idx_next;
                    w_show_nxt            = 1'b0;
                    w_err_nxt             = 1'b0;
                    w_op_valid_nxt        = 1'b0;
                end
            end
            default: w_state_nxt = ST_ENTER_A;
        endcase
        // Applied last so an op key pressed alongside a new-entry bit still sticks.
        if (w_op_pulse && (r_state != ST_EXEC)) begin
            w_op_valid_nxt = 1'b1;
            w_op_sub_nxt   = w_press[3];
        end
    end

endmodule
`default_nettype wire
